// File: rtl/register_universal_nbit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_universal_nbit_pkg
// Description : Operation encodings and helpers shared by the universal
//               register and the control unit that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
package register_universal_nbit_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    // Every encoding except HOLD rewrites the value, carry and zero flags.
    function automatic logic op_writes(input logic [2:0] op);
        return (op != OP_HOLD);
    endfunction

endpackage : register_universal_nbit_pkg
`default_nettype wire

// File: rtl/register_universal_nbit_next.sv
`default_nettype none
// ============================================================================
// Module      : register_universal_next
// Description : Purely combinational next-value / next-carry generator for
//               the universal register. HOLD returns the current value; the
//               top level decides whether the result is written at all.
// Revision    : 1.0 - initial release
// ============================================================================
module register_universal_next
    import register_universal_nbit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_value,
    input  logic [N-1:0] i_data,
    input  logic         i_serial,
    output logic [N-1:0] o_next_value,
    output logic         o_next_carry
);

    logic [N-1:0] w_shl;
    logic [N-1:0] w_shr;
    logic [N-1:0] w_rol;
    logic [N-1:0] w_ror;

    // A one-bit register has no "remaining" bits to move, so shifts collapse
    // to taking serial_in and rotates leave the bit where it is.
    generate
        if (N > 1) begin : g_wide
            assign w_shl = {i_value[N-2:0], i_serial};
            assign w_shr = {i_serial, i_value[N-1:1]};
            assign w_rol = {i_value[N-2:0], i_value[N-1]};
            assign w_ror = {i_value[0], i_value[N-1:1]};
        end else begin : g_narrow
            assign w_shl = i_serial;
            assign w_shr = i_serial;
            assign w_rol = i_value;
            assign w_ror = i_value;
        end
    endgenerate

    // Select the operation result and the bit that falls out of it.
    always_comb begin
        o_next_value = i_value;
        o_next_carry = 1'b0;
        case (i_op)
            OP_LOAD: begin
                o_next_value = i_data;
            end
            OP_INC: begin
                o_next_value = i_value + N'(1);
                o_next_carry = &i_value;
            end
            OP_DEC: begin
                o_next_value = i_value - N'(1);
                o_next_carry = ~|i_value;
            end
            OP_SHL: begin
                o_next_value = w_shl;
                o_next_carry = i_value[N-1];
            end
            OP_SHR: begin
                o_next_value = w_shr;
                o_next_carry = i_value[0];
            end
            OP_ROL: begin
                o_next_value = w_rol;
                o_next_carry = i_value[N-1];
            end
            OP_ROR: begin
                o_next_value = w_ror;
                o_next_carry = i_value[0];
            end
            default: begin
                o_next_value = i_value;
                o_next_carry = 1'b0;
            end
        endcase
    end

endmodule : register_universal_next
`default_nettype wire

// File: rtl/register_universal_nbit.sv
`default_nettype none
// ============================================================================
// Module      : register_universal_nbit
// Description : N-bit register with hold/load/inc/dec/shift/rotate operations
//               and registered carry and zero flags. All outputs are flops.
// Revision    : 1.0 - initial release
// ============================================================================
module register_universal_nbit
    import register_universal_nbit_pkg::*;
#(
    parameter int             N           = 8,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [2:0]   op,
    input  logic [N-1:0] data_in,
    input  logic         serial_in,
    output logic [N-1:0] data_out,
    output logic         carry,
    output logic         zero
);

    logic [N-1:0] r_value;
    logic         r_carry;
    logic         r_zero;

    logic [N-1:0] w_next_value;
    logic         w_next_carry;

    register_universal_next #(
        .N (N)
    ) u_next (
        .i_op         (op),
        .i_value      (r_value),
        .i_data       (data_in),
        .i_serial     (serial_in),
        .o_next_value (w_next_value),
        .o_next_carry (w_next_carry)
    );

    // State update: reset > clr > enabled writing op > hold. Zero is derived
    // from the value being written so it is always coherent with data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= RESET_VALUE;
            r_carry <= 1'b0;
            r_zero  <= (RESET_VALUE == '0);
        end else if (clr) begin
            r_value <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
        end else if (en && op_writes(op)) begin
            r_value <= w_next_value;
            r_carry <= w_next_carry;
            r_zero  <= (w_next_value == '0);
        end
    end

    assign data_out = r_value;
    assign carry    = r_carry;
    assign zero     = r_zero;

endmodule : register_universal_nbit
`default_nettype wire
